// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the hazard unit.
package hazard_pkg;

  // Forwarding select encodings for the E-stage operand muxes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Divide-occupancy FSM state encodings
  localparam logic [0:0] DIV_IDLE = 1'b0;
  localparam logic [0:0] DIV_BUSY = 1'b1;

  // Register-number match; r0 never matches anything
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_unit_div_stall_fsm.sv
// Divide-occupancy FSM: holds E while a multi-cycle divide is in flight.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic divE,
  output logic div_startE,
  output logic div_doneE,
  output logic divstall
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;

  // State and counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and pulse logic; reset masks the pulses and the stall
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    div_startE  = 1'b0;
    div_doneE   = 1'b0;
    w_last      = (r_state == DIV_BUSY) && (r_cnt == '0);
    case (r_state)
      DIV_IDLE: begin
        if (divE) begin
          div_startE  = 1'b1;
          w_cnt_nxt   = CNT_W'(DIV_CYCLES - 2);
          w_state_nxt = DIV_BUSY;
        end
      end
      default: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          div_doneE   = 1'b1;
          w_state_nxt = DIV_IDLE;
        end
      end
    endcase
    if (rst) begin
      div_startE = 1'b0;
      div_doneE  = 1'b0;
    end
    divstall = divE && !w_last && !rst;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard resolver: forwarding, load/branch stalls and divide freeze.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       divE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       flushM,
  output logic       forwardaD,
  output logic       forwardbD,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE,
  output logic       div_startE,
  output logic       div_doneE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic w_lwstall;
  logic w_branchstall;
  logic w_divstall;
  logic w_hit_rs;
  logic w_hit_rt;

  div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk        (clk),
    .rst        (rst),
    .divE       (divE),
    .div_startE (div_startE),
    .div_doneE  (div_doneE),
    .divstall   (w_divstall)
  );

  // E-stage forwarding selects; M has priority over W
  always_comb begin
    forwardaE = FWD_RF;
    forwardbE = FWD_RF;
    if (regwriteM && reg_match(rsE, writeregM))      forwardaE = FWD_M;
    else if (regwriteW && reg_match(rsE, writeregW)) forwardaE = FWD_W;
    if (regwriteM && reg_match(rtE, writeregM))      forwardbE = FWD_M;
    else if (regwriteW && reg_match(rtE, writeregW)) forwardbE = FWD_W;
  end

  // Hazard detection and stall/flush merge
  always_comb begin
    forwardaD     = regwriteM && reg_match(rsD, writeregM);
    forwardbD     = regwriteM && reg_match(rtD, writeregM);
    w_lwstall     = memtoregE && (reg_match(rsD, writeregE) || reg_match(rtD, writeregE));
    w_hit_rs      = (regwriteE && reg_match(rsD, writeregE)) ||
                    (memtoregM && reg_match(rsD, writeregM));
    w_hit_rt      = (regwriteE && reg_match(rtD, writeregE)) ||
                    (memtoregM && reg_match(rtD, writeregM));
    w_branchstall = (branchD && (w_hit_rs || w_hit_rt)) || (jrD && w_hit_rs);
    stallF        = w_lwstall || w_branchstall || w_divstall;
    stallD        = stallF;
    stallE        = w_divstall;
    flushM        = w_divstall;
    flushE        = (w_lwstall || w_branchstall) && !w_divstall;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Stall/flush cycle counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (stallD) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (flushE) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
